residual_packer: RTL

Downstream stage of the header/residual encoder. It accepts one encoded block per handshake: an 8-bit base, a 4-bit residual width k and 16 signed residuals. It emits a header word followed by the low k bits of each residual, packed LSB-first into 32-bit words over a valid/ready stream. The stream feeds the link transmit FIFO.

---
 rtl/residual_packer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/residual_packer.sv
`default_nettype none
// ============================================================================
// Module   : residual_packer
// Purpose  : Emits a header word, then the low k bits of each residual,
//            packed LSB-first into OUT_W-bit valid/ready stream words.
// Revision : 1.0  initial release
// ============================================================================
module residual_packer #(
    parameter int N_PIX = 16,
    parameter int RES_W = 8,
    parameter int OUT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_base,
    input  logic [3:0]             in_width,
    input  logic [N_PIX*RES_W-1:0] in_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_last
);
    localparam int BUF_W = 2 * OUT_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int IDX_W = $clog2(N_PIX + 1);
    localparam logic [CNT_W-1:0] C_WORD_BITS = CNT_W'(OUT_W);
    localparam logic [IDX_W-1:0] C_END_IDX   = IDX_W'(N_PIX);
    localparam logic [3:0]       C_KC_MAX    = 4'(RES_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PACK = 2'd2
    } state_t;

    state_t                   r_state,  w_state;
    logic [7:0]               r_base,   w_base;
    logic [3:0]               r_kc,     w_kc;
    logic [N_PIX*RES_W-1:0]   r_res,    w_res;
    logic [BUF_W-1:0]         r_buf,    w_buf;
    logic [CNT_W-1:0]         r_cnt,    w_cnt;
    logic [IDX_W-1:0]         r_idx,    w_idx;

    logic                     r_in_ready,  w_in_ready;
    logic                     r_out_valid, w_out_valid;
    logic [OUT_W-1:0]         r_out_data,  w_out_data;
    logic                     r_out_last,  w_out_last;

    logic [IDX_W-1:0]         w_sel_idx;
    logic [RES_W-1:0]         w_res_sel;
    logic [RES_W-1:0]         w_mask;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // Index guarded so the part-select never leaves the residual vector.
    assign w_sel_idx = (r_idx < C_END_IDX) ? r_idx : '0;
    assign w_res_sel = r_res[int'(w_sel_idx)*RES_W +: RES_W];
    assign w_mask    = {RES_W{1'b1}} >> (RES_W - int'(r_kc));

    always_comb begin
        w_state = r_state;
        w_base  = r_base;
        w_kc    = r_kc;
        w_res   = r_res;
        w_buf   = r_buf;
        w_cnt   = r_cnt;
        w_idx   = r_idx;

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_base  = in_base;
                    w_kc    = (in_width > C_KC_MAX) ? C_KC_MAX : in_width;
                    w_res   = in_res;
                    w_buf   = '0;
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_state = S_HDR;
                end
            end
            S_HDR: begin
                if (out_ready) begin
                    w_state = (r_kc == 4'd0) ? S_IDLE : S_PACK;
                end
            end
            S_PACK: begin
                // Append only while a word is incomplete, so it never collides with a pop.
                if (r_cnt < C_WORD_BITS && r_idx < C_END_IDX) begin
                    w_buf = r_buf | (BUF_W'(w_res_sel & w_mask) << r_cnt);
                    w_cnt = r_cnt + CNT_W'(r_kc);
                    w_idx = r_idx + IDX_W'(1);
                end else if (r_out_valid && out_ready) begin
                    w_buf = r_buf >> OUT_W;
                    w_cnt = (r_cnt > C_WORD_BITS) ? (r_cnt - C_WORD_BITS) : '0;
                    if (r_out_last) begin
                        w_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_in_ready  = (w_state == S_IDLE);
        w_out_valid = 1'b0;
        w_out_data  = '0;
        w_out_last  = 1'b0;
        if (w_state == S_HDR) begin
            w_out_valid = 1'b1;
            w_out_data  = OUT_W'({w_kc, w_base});
            w_out_last  = (w_kc == 4'd0);
        end else if (w_state == S_PACK) begin
            w_out_valid = (w_cnt >= C_WORD_BITS) || (w_idx == C_END_IDX && w_cnt != '0);
            w_out_data  = w_buf[OUT_W-1:0];
            w_out_last  = w_out_valid && (w_idx == C_END_IDX) && (w_cnt <= C_WORD_BITS);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_kc        <= '0;
            r_res       <= '0;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_base      <= w_base;
            r_kc        <= w_kc;
            r_res       <= w_res;
            r_buf       <= w_buf;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_out_last  <= w_out_last;
        end
    end

endmodule
`default_nettype wire
